// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with configurable wait states,
// per-byte store strobes and an internal word-addressed RAM.
module dmem_responder #(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth    = 1 << AW;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [Depth];

  logic        access;
  logic        accept;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;
  logic [AW-1:0] acc_idx;
  logic        acc_fault;
  logic [31:0] rd_word;
  logic        mem_we;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_ready & req_valid;

  // With no wait states the access happens on the accept edge, so it must see the live request
  if (WAIT_STATES == 0) begin : g_direct
    assign acc_we    = req_we;
    assign acc_addr  = req_addr;
    assign acc_wdata = req_wdata;
    assign acc_be    = req_be;
  end else begin : g_latched
    assign acc_we    = we_q;
    assign acc_addr  = addr_q;
    assign acc_wdata = wdata_q;
    assign acc_be    = be_q;
  end

  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_fault = (acc_addr[1:0] != 2'b00) | ((acc_addr >> (AW + 2)) != 32'd0);
  assign rd_word   = mem[acc_idx];
  // rstn gate keeps a store from landing on an edge that occurs while reset is held
  assign mem_we    = access & rstn & acc_we & ~acc_fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = WaitInit;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access) begin
      err_d   = acc_fault;
      rdata_d = (acc_fault | acc_we) ? 32'd0 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
